fire_alarm_ctrl: RTL and testbench
==================================

Name: fire_alarm_ctrl

Overview:
- Upstream stage of the fire-sensor display path.
- Synchronises and debounces the raw flame-sensor input and the acknowledge push-button.
- Runs the alarm state machine: SAFE -> SUSPECT -> FIRE -> CLEARING.
- Emits a 2-bit message code that the 4-digit seven-segment driver decodes to SAFE / CHEC / FIRE / CLr, plus LED, buzzer and event-count outputs.

Parameters:
- DEBOUNCE_CYC, 1_000_000: cycles an input must differ from its debounced value before the debounced value flips (10 ms at 100 MHz).
- CONFIRM_CYC, 50_000_000: cycles a debounced flame must persist in SUSPECT before FIRE is declared.
- BUZZ_HALF, 25_000_000: buzzer half-period in FIRE.
- CLEAR_CYC, 200_000_000: flame-free cycles required in CLEARING before returning to SAFE.

Ports:
- clk  in  1  system clock, 100 MHz; all logic on the falling edge, matching the display driver.
- rst_0  in  1  asynchronous, active-low reset.
- flame_n  in  1  raw sensor output, low = flame, asynchronous.
- ack_btn  in  1  raw acknowledge button, high = pressed, asynchronous.
- msg  out  2  00 SAFE, 01 SUSPECT, 10 FIRE, 11 CLEARING.
- alarm_led  out  1  alarm indicator.
- buzzer  out  1  buzzer drive.
- fire_count  out  8  confirmed fire events, saturating.

Behaviour:
- Reset (rst_0=0, asynchronous):
  - state=SAFE; msg=00; alarm_led=0; buzzer=0; fire_count=0; timer=0.
  - flame synchroniser and debounced value =1; ack synchroniser and debounced value =0.
- Synchronisers: 2-flop on each raw input.
- Debounce (per input): a counter increments while the synchronised value differs from the debounced value and clears when they are equal. On reaching DEBOUNCE_CYC-1 the debounced value takes the synchronised value and the counter clears.
- Derived signals:
  - flame_det = ~flame_db.
  - ack_pulse = one-cycle pulse on the rising edge of ack_db.
- Shared timer: width = clog2 of the largest parameter. Clears on every state change and otherwise counts up in SUSPECT, FIRE and CLEARING.
- State transitions (registered):
  - SAFE: flame_det=1 -> SUSPECT.
  - SUSPECT:
    - flame_det=0 -> SAFE.
    - else timer==CONFIRM_CYC-1 -> FIRE; fire_count += 1, holding at 255.
  - FIRE: ack_pulse=1 and flame_det=0 -> CLEARING. ack_pulse while flame_det=1 is ignored, and the alarm stays latched.
  - CLEARING:
    - flame_det=1 -> FIRE, with no count increment (same event).
    - else timer==CLEAR_CYC-1 -> SAFE.
  - If flame_det drops and ack_pulse arrives in the same cycle in FIRE, the transition to CLEARING is taken.
- Outputs (Moore, decoded from the state register; they change in the same cycle as the state):
  - msg as encoded above.
  - alarm_led=1 in FIRE and CLEARING.
  - buzzer toggles each BUZZ_HALF cycles in FIRE and starts at 1 on FIRE entry; buzzer is forced to 0 in every other state.
- Latency: a clean flame_n fall reaches SUSPECT after 2 (sync) + DEBOUNCE_CYC + 1 cycles.
- Reset asserted mid-operation: immediate return to the reset values, including fire_count.

Decomposition:
- Package fire_pkg holds:
  - the state encoding SAFE/SUSPECT/FIRE/CLEARING;
  - the MSG_* constants shared with the display driver;
  - the timer width function.
- Sub-module sync_debounce (parameter DEBOUNCE_CYC, reset value parameter INIT):
  - contains the 2-flop synchroniser and the debounce counter;
  - instantiated for flame_n (INIT=1) and for ack_btn (INIT=0).

Test Plan (DEBOUNCE_CYC=4, CONFIRM_CYC=20, BUZZ_HALF=5, CLEAR_CYC=30):
- Release reset with flame_n=1 for 100 cycles -> msg=00, alarm_led=0, buzzer=0, fire_count=0 throughout.
- flame_n=0 held -> msg=01 at cycle 7 after the fall, msg=10 20 cycles later, fire_count=1. In FIRE, buzzer is 1 for 5 cycles then 0 for 5 cycles, repeating.
- flame_n glitches low for 3 cycles, then low for 10 cycles and released -> state never leaves SAFE for the glitch. The long pulse reaches SUSPECT then returns to SAFE; fire_count unchanged.
- In FIRE with flame present, pulse ack_btn for 10 cycles -> stays FIRE. Release flame, then ack -> msg=11, buzzer=0, alarm_led=1; after 30 flame-free cycles msg=00.
- In CLEARING, reassert flame -> msg=10 again; fire_count unchanged. Drive 256 separate confirmed events -> fire_count holds 255.
- Assert rst_0 low asynchronously mid-FIRE, between clock edges -> all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fire_pkg.sv
// Shared definitions for the fire-alarm path: state encoding, display message
// codes and the sizing helper for the controller's shared timer.
package fire_pkg;

  typedef enum logic [1:0] {
    ST_SAFE     = 2'b00,
    ST_SUSPECT  = 2'b01,
    ST_FIRE     = 2'b10,
    ST_CLEARING = 2'b11
  } state_t;

  // Codes the seven-segment driver turns into SAFE / CHEC / FIRE / CLr
  localparam logic [1:0] MSG_SAFE = 2'b00;
  localparam logic [1:0] MSG_CHEC = 2'b01;
  localparam logic [1:0] MSG_FIRE = 2'b10;
  localparam logic [1:0] MSG_CLR  = 2'b11;

  // Timer is sized for the longest interval among the block's parameters
  function automatic int timer_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic [1:0] msg_code(input state_t s);
    case (s)
      ST_SAFE:     return MSG_SAFE;
      ST_SUSPECT:  return MSG_CHEC;
      ST_FIRE:     return MSG_FIRE;
      ST_CLEARING: return MSG_CLR;
      default:     return MSG_SAFE;
    endcase
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a counter debouncer. The debounced value
// only follows the synchronised input after it has differed for DEBOUNCE_CYC
// consecutive cycles. Runs on the falling clock edge like the rest of the path.
module sync_debounce #(
  parameter int   DEBOUNCE_CYC = 1_000_000,
  parameter logic INIT         = 1'b0
) (
  input  logic clk,
  input  logic rst_0,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Synchronise, then count cycles of disagreement before accepting the new level
  always_ff @(negedge clk or negedge rst_0) begin
    if (!rst_0) begin
      s1   <= INIT;
      s2   <= INIT;
      dout <= INIT;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 != dout) begin
        if (cnt == LAST) begin
          dout <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fire_alarm_ctrl.sv
// Fire-alarm controller: conditions the flame sensor and acknowledge button,
// runs SAFE -> SUSPECT -> FIRE -> CLEARING and drives the display code, LED,
// buzzer and a saturating count of confirmed fire events.
module fire_alarm_ctrl
  import fire_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CONFIRM_CYC  = 50_000_000,
  parameter int BUZZ_HALF    = 25_000_000,
  parameter int CLEAR_CYC    = 200_000_000
) (
  input  logic       clk,
  input  logic       rst_0,
  input  logic       flame_n,
  input  logic       ack_btn,
  output logic [1:0] msg,
  output logic       alarm_led,
  output logic       buzzer,
  output logic [7:0] fire_count
);

  localparam int TW = timer_w(DEBOUNCE_CYC, CONFIRM_CYC, BUZZ_HALF, CLEAR_CYC);
  localparam logic [TW-1:0] CONF_LAST = TW'(CONFIRM_CYC - 1);
  localparam logic [TW-1:0] CLR_LAST  = TW'(CLEAR_CYC - 1);
  localparam logic [TW-1:0] BUZZ_LAST = TW'(BUZZ_HALF - 1);

  logic          flame_db, ack_db, ack_prev;
  logic          flame_det, ack_pulse, count_evt;
  state_t        state, nxt;
  logic [TW-1:0] timer, bcnt;

  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INIT(1'b1)) u_flame (
    .clk(clk), .rst_0(rst_0), .din(flame_n), .dout(flame_db)
  );

  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INIT(1'b0)) u_ack (
    .clk(clk), .rst_0(rst_0), .din(ack_btn), .dout(ack_db)
  );

  assign flame_det = ~flame_db;
  assign ack_pulse = ack_db & ~ack_prev;

  // Remember the debounced button so a press yields exactly one pulse
  always_ff @(negedge clk or negedge rst_0) begin
    if (!rst_0) ack_prev <= 1'b0;
    else        ack_prev <= ack_db;
  end

  // Next-state decision; an ack while flame is still present is ignored
  always_comb begin
    nxt       = state;
    count_evt = 1'b0;
    case (state)
      ST_SAFE:
        if (flame_det) nxt = ST_SUSPECT;
      ST_SUSPECT:
        if (!flame_det) nxt = ST_SAFE;
        else if (timer == CONF_LAST) begin
          nxt       = ST_FIRE;
          count_evt = 1'b1;
        end
      ST_FIRE:
        if (ack_pulse && !flame_det) nxt = ST_CLEARING;
      ST_CLEARING:
        if (flame_det) nxt = ST_FIRE;
        else if (timer == CLR_LAST) nxt = ST_SAFE;
      default:
        nxt = ST_SAFE;
    endcase
  end

  // State, timer and Moore outputs registered together from the next state
  always_ff @(negedge clk or negedge rst_0) begin
    if (!rst_0) begin
      state      <= ST_SAFE;
      timer      <= '0;
      bcnt       <= '0;
      msg        <= MSG_SAFE;
      alarm_led  <= 1'b0;
      buzzer     <= 1'b0;
      fire_count <= '0;
    end else begin
      state     <= nxt;
      msg       <= msg_code(nxt);
      alarm_led <= (nxt == ST_FIRE) || (nxt == ST_CLEARING);

      if (nxt != state)         timer <= '0;
      else if (state != ST_SAFE) timer <= timer + 1'b1;

      // Buzzer starts high on FIRE entry and flips every BUZZ_HALF cycles
      if (nxt == ST_FIRE) begin
        if (state != ST_FIRE) begin
          buzzer <= 1'b1;
          bcnt   <= '0;
        end else if (bcnt == BUZZ_LAST) begin
          buzzer <= ~buzzer;
          bcnt   <= '0;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end else begin
        buzzer <= 1'b0;
        bcnt   <= '0;
      end

      if (count_evt && fire_count != 8'hFF) fire_count <= fire_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Bench for fire_alarm_ctrl: directed scenarios plus random flame/ack traffic,
// every cycle compared against a time-in-state reference model.
module tb_fire_alarm_ctrl;

  localparam int DB  = 4;
  localparam int CF  = 20;
  localparam int BH  = 5;
  localparam int CLR = 30;

  logic       clk = 1'b0;
  logic       rst_0, flame_n, ack_btn;
  logic [1:0] msg;
  logic       alarm_led, buzzer;
  logic [7:0] fire_count;

  int n_chk = 0;
  int n_bad = 0;

  // stimulus levels applied by cyc()
  logic f_in, a_in;

  // reference model
  int m_st;      // 0 SAFE, 1 SUSPECT, 2 FIRE, 3 CLEARING
  int m_t;       // cycles spent in current state
  int m_cnt;
  bit f_hist[$];
  bit a_hist[$];
  bit f_db, a_db, a_prev;
  int f_run, a_run;

  fire_alarm_ctrl #(
    .DEBOUNCE_CYC(DB), .CONFIRM_CYC(CF), .BUZZ_HALF(BH), .CLEAR_CYC(CLR)
  ) dut (
    .clk(clk), .rst_0(rst_0), .flame_n(flame_n), .ack_btn(ack_btn),
    .msg(msg), .alarm_led(alarm_led), .buzzer(buzzer), .fire_count(fire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_t = 0; m_cnt = 0;
    f_hist = '{1'b1, 1'b1};
    a_hist = '{1'b0, 1'b0};
    f_db = 1'b1; a_db = 1'b0; a_prev = 1'b0;
    f_run = 0; a_run = 0;
  endtask

  // Level l must disagree with the accepted level for DB cycles in a row
  task automatic debounce(input bit seen, inout bit db, inout int run);
    if (seen != db) begin
      run++;
      if (run == DB) begin
        db  = seen;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic m_step(input bit fl, input bit ak);
    bit fdet, ap, fs, as;
    fdet = !f_db;
    ap   = a_db && !a_prev;
    case (m_st)
      0: if (fdet) begin m_st = 1; m_t = 0; end
      1: if (!fdet) begin m_st = 0; m_t = 0; end
         else if (m_t == CF - 1) begin
           m_st = 2; m_t = 0;
           if (m_cnt < 255) m_cnt++;
         end else m_t++;
      2: if (ap && !fdet) begin m_st = 3; m_t = 0; end
         else m_t++;
      default:
         if (fdet) begin m_st = 2; m_t = 0; end
         else if (m_t == CLR - 1) begin m_st = 0; m_t = 0; end
         else m_t++;
    endcase
    a_prev = a_db;
    // raw inputs reach the debouncer two cycles later
    fs = f_hist[0];
    as = a_hist[0];
    debounce(fs, f_db, f_run);
    debounce(as, a_db, a_run);
    f_hist.push_back(fl); void'(f_hist.pop_front());
    a_hist.push_back(ak); void'(a_hist.pop_front());
  endtask

  function automatic bit exp_buz();
    return (m_st == 2) && (((m_t / BH) % 2) == 0);
  endfunction

  // Drive one cycle of input, advance model and DUT, then compare
  task automatic cyc();
    flame_n = f_in;
    ack_btn = a_in;
    m_step(f_in, a_in);
    @(posedge clk);
    chk("msg",   32'(msg),        32'(m_st));
    chk("led",   32'(alarm_led),  32'(m_st >= 2));
    chk("buz",   32'(buzzer),     32'(exp_buz()));
    chk("count", 32'(fire_count), 32'(m_cnt));
  endtask

  task automatic run(input bit f, input bit a, input int n);
    f_in = f;
    a_in = a;
    repeat (n) cyc();
  endtask

  initial begin
    int n;
    int saved;
    rst_0 = 1'b0; flame_n = 1'b1; ack_btn = 1'b0;
    f_in = 1'b1; a_in = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    chk("rst_msg",   32'(msg),        32'd0);
    chk("rst_led",   32'(alarm_led),  32'd0);
    chk("rst_buz",   32'(buzzer),     32'd0);
    chk("rst_count", 32'(fire_count), 32'd0);
    rst_0 = 1'b1;

    // idle with no flame
    run(1'b1, 1'b0, 100);

    // sustained flame: SUSPECT latency, then FIRE with buzzer cadence
    f_in = 1'b0; a_in = 1'b0;
    n = 0;
    while (n < 20 && msg != 2'b01) begin cyc(); n++; end
    chk("susp_latency", 32'(n), 32'd7);
    run(1'b0, 1'b0, 60);
    chk("first_fire_cnt", 32'(fire_count), 32'd1);

    // ack ignored while flame present
    run(1'b0, 1'b1, 10);
    run(1'b0, 1'b0, 10);
    chk("ack_ignored", 32'(msg), 32'd2);

    // flame gone, ack -> CLEARING -> SAFE
    run(1'b1, 1'b0, 10);
    run(1'b1, 1'b1, 10);
    run(1'b1, 1'b0, 40);
    chk("back_safe", 32'(msg), 32'd0);

    // short glitch, then a pulse that only reaches SUSPECT
    saved = fire_count;
    run(1'b0, 1'b0, 3);
    run(1'b1, 1'b0, 20);
    run(1'b0, 1'b0, 10);
    run(1'b1, 1'b0, 30);
    chk("cnt_keep", 32'(fire_count), 32'(saved));

    // fire, clear, then flame returns during CLEARING
    run(1'b0, 1'b0, 35);
    run(1'b1, 1'b0, 8);
    run(1'b1, 1'b1, 8);
    run(1'b1, 1'b0, 5);
    chk("in_clearing", 32'(msg), 32'd3);
    saved = fire_count;
    run(1'b0, 1'b0, 12);
    chk("refire_msg", 32'(msg), 32'd2);
    chk("refire_cnt", 32'(fire_count), 32'(saved));
    run(1'b1, 1'b0, 8);
    run(1'b1, 1'b1, 8);
    run(1'b1, 1'b0, 36);

    // random traffic
    repeat (150) begin
      f_in = 1'($urandom_range(0, 1));
      a_in = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 30)) cyc();
    end
    run(1'b1, 1'b0, 10);
    run(1'b1, 1'b1, 8);
    run(1'b1, 1'b0, 40);

    // enough confirmed events to saturate the counter
    for (int e = 0; e < 256; e++) begin
      run(1'b0, 1'b0, 30);
      run(1'b1, 1'b0, 8);
      run(1'b1, 1'b1, 8);
      run(1'b1, 1'b0, 36);
    end
    chk("saturate", 32'(fire_count), 32'd255);

    // asynchronous reset in FIRE, between clock edges
    run(1'b0, 1'b0, 35);
    chk("pre_arst", 32'(msg), 32'd2);
    #2 rst_0 = 1'b0;
    #1;
    chk("arst_msg",   32'(msg),        32'd0);
    chk("arst_led",   32'(alarm_led),  32'd0);
    chk("arst_buz",   32'(buzzer),     32'd0);
    chk("arst_count", 32'(fire_count), 32'd0);
    m_reset();
    flame_n = 1'b1; f_in = 1'b1;
    @(posedge clk);
    rst_0 = 1'b1;
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 40);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
